// File: rtl/fpmul_pkg.sv
// Shared types and constants for the sequential single-precision multiplier.
// Special-operand classification is centralised here so controller and any future datapath agree.
package fpmul_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int MANT_W = FRAC_W + 1;
  localparam int PROD_W = 2 * MANT_W;
  localparam int ITER   = MANT_W;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] INF_MAG = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MULT,
    NORM,
    ROUND,
    PACK,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SPC_NONE,
    SPC_NAN,
    SPC_INF,
    SPC_ZERO
  } spec_t;

  // Denormals count as zero because they are flushed before the multiply.
  function automatic spec_t classify(input logic [31:0] a, input logic [31:0] b);
    logic a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    a_max  = &a[FRAC_W+EXP_W-1:FRAC_W];
    b_max  = &b[FRAC_W+EXP_W-1:FRAC_W];
    a_zero = ~|a[FRAC_W+EXP_W-1:FRAC_W];
    b_zero = ~|b[FRAC_W+EXP_W-1:FRAC_W];
    a_nan  = a_max & (|a[FRAC_W-1:0]);
    b_nan  = b_max & (|b[FRAC_W-1:0]);
    a_inf  = a_max & ~(|a[FRAC_W-1:0]);
    b_inf  = b_max & ~(|b[FRAC_W-1:0]);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      classify = SPC_NAN;
    end else if (a_inf || b_inf) begin
      classify = SPC_INF;
    end else if (a_zero || b_zero) begin
      classify = SPC_ZERO;
    end else begin
      classify = SPC_NONE;
    end
  endfunction

endpackage

// File: rtl/fpmul_seq_ctrl_if.sv
// Issue-side handshake bundle: start/operands in, busy/done/result/ovf back.
// Issue logic drives the master side; the multiplier presents the slave side.
interface fpmul_seq_ctrl_if;

  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;

  modport master (
    output start,
    output op_a,
    output op_b,
    input  busy,
    input  done,
    input  result,
    input  ovf
  );

  modport slave (
    input  start,
    input  op_a,
    input  op_b,
    output busy,
    output done,
    output result,
    output ovf
  );

endinterface

// File: rtl/fp_round_inc.sv
// Combinational fraction incrementer; carry-out flags a mantissa wrap that bumps the exponent.
// Zero latency, no flow control.
module fp_round_inc
  import fpmul_pkg::*;
#(
  parameter int W = FRAC_W
) (
  input  logic [W-1:0] i_frac,
  input  logic         i_inc,
  output logic [W-1:0] o_frac,
  output logic         o_carry
);

  assign {o_carry, o_frac} = {1'b0, i_frac} + {{W{1'b0}}, i_inc};

endmodule

// File: rtl/fpmul_seq_ctrl.sv
// Iterative FP32 multiplier: done 28 cycles after start (2 for special operands); start ignored unless IDLE.
// Define FPMUL_RNE_EN for round-to-nearest-even; otherwise exact ties truncate.
module fpmul_seq_ctrl
  import fpmul_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  fpmul_seq_ctrl_if.slave bus
);

  state_t                r_state;
  logic [4:0]            r_cnt;
  logic [31:0]           r_op_a;
  logic [31:0]           r_op_b;
  logic                  r_sign;
  spec_t                 r_spec;
  logic signed [9:0]     r_exp;
  logic [PROD_W-1:0]     r_mcand;
  logic [MANT_W-1:0]     r_mplier;
  logic [PROD_W-1:0]     r_acc;
  logic [FRAC_W-1:0]     r_frac;
  logic                  r_rbit;
  logic                  r_sbit;
  logic                  r_busy;
  logic                  r_done;
  logic [31:0]           r_result;
  logic                  r_ovf;

  logic [EXP_W-1:0]      w_ea;
  logic [EXP_W-1:0]      w_eb;
  logic [MANT_W-1:0]     w_ma;
  logic [MANT_W-1:0]     w_mb;
  logic signed [9:0]     w_exp_sum;
  spec_t                 w_spec;
  logic                  w_round_up;
  logic [FRAC_W-1:0]     w_frac_rnd;
  logic                  w_carry;

  assign w_ea      = r_op_a[FRAC_W+EXP_W-1:FRAC_W];
  assign w_eb      = r_op_b[FRAC_W+EXP_W-1:FRAC_W];
  assign w_ma      = {|w_ea, r_op_a[FRAC_W-1:0]};
  assign w_mb      = {|w_eb, r_op_b[FRAC_W-1:0]};
  assign w_exp_sum = $signed({2'b00, w_ea} + {2'b00, w_eb} - 10'(BIAS));
  assign w_spec    = classify(r_op_a, r_op_b);

`ifdef FPMUL_RNE_EN
  assign w_round_up = r_rbit & (r_sbit | r_frac[0]);
`else
  assign w_round_up = r_rbit & r_sbit;
`endif

  fp_round_inc #(.W(FRAC_W)) u_round_inc (
    .i_frac  (r_frac),
    .i_inc   (w_round_up),
    .o_frac  (w_frac_rnd),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_sign   <= 1'b0;
      r_spec   <= SPC_NONE;
      r_exp    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_frac   <= '0;
      r_rbit   <= 1'b0;
      r_sbit   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op_a  <= bus.op_a;
            r_op_b  <= bus.op_b;
            r_busy  <= 1'b1;
            r_state <= UNPACK;
          end
        end

        UNPACK: begin
          r_sign   <= r_op_a[31] ^ r_op_b[31];
          r_spec   <= w_spec;
          r_exp    <= w_exp_sum;
          r_mcand  <= {{(PROD_W-MANT_W){1'b0}}, w_ma};
          r_mplier <= w_mb;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_state  <= (w_spec != SPC_NONE) ? PACK : MULT;
        end

        // LSB-first shift-add: multiplicand walks left as multiplier walks right.
        MULT: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == 5'(ITER - 1)) begin
            r_cnt   <= '0;
            r_state <= NORM;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end

        NORM: begin
          if (r_acc[PROD_W-1]) begin
            r_frac <= r_acc[PROD_W-2:PROD_W-1-FRAC_W];
            r_rbit <= r_acc[PROD_W-2-FRAC_W];
            r_sbit <= |r_acc[PROD_W-3-FRAC_W:0];
            r_exp  <= r_exp + 10'sd1;
          end else begin
            r_frac <= r_acc[PROD_W-3:PROD_W-2-FRAC_W];
            r_rbit <= r_acc[PROD_W-3-FRAC_W];
            r_sbit <= |r_acc[PROD_W-4-FRAC_W:0];
          end
          r_state <= ROUND;
        end

        ROUND: begin
          r_frac <= w_frac_rnd;
          if (w_carry) begin
            r_exp <= r_exp + 10'sd1;
          end
          r_state <= PACK;
        end

        PACK: begin
          case (r_spec)
            SPC_NAN: begin
              r_result <= QNAN;
              r_ovf    <= 1'b0;
            end
            SPC_INF: begin
              r_result <= {r_sign, INF_MAG[30:0]};
              r_ovf    <= 1'b1;
            end
            SPC_ZERO: begin
              r_result <= {r_sign, 31'd0};
              r_ovf    <= 1'b0;
            end
            default: begin
              if (r_exp >= 10'sd255) begin
                r_result <= {r_sign, INF_MAG[30:0]};
                r_ovf    <= 1'b1;
              end else if (r_exp <= 10'sd0) begin
                r_result <= {r_sign, 31'd0};
                r_ovf    <= 1'b0;
              end else begin
                r_result <= {r_sign, r_exp[EXP_W-1:0], r_frac};
                r_ovf    <= 1'b0;
              end
            end
          endcase
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= DONE;
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.ovf    = r_ovf;

endmodule

// File: doc/fpmul_seq_ctrl.md
Name: fpmul_seq_ctrl

Overview:
- Iterative IEEE-754 single-precision multiplier controller with a start/busy/done handshake.
- Sequences the operations in order: unpack, 24-step shift-add mantissa multiply, normalise, round, pack.
- The round step uses the team's mantissa-increment semantics: guard bit r, sticky bit s.
- Sits between the CPU FP issue logic and the register-file writeback.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, fraction field width. Iteration count is FRAC_W+1.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse. Sampled only in IDLE.
- op_a  input  32  operand A. Captured on the accepted start edge.
- op_b  input  32  operand B. Captured on the accepted start edge.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse; result is valid.
- result  output  32  product. Held until the next accepted start.
- ovf  output  1  result overflowed to infinity. Valid with done.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; busy=0, done=0, result=0, ovf=0; iteration counter=0.
  - Reset mid-operation abandons the operation. No done is produced.
- FSM:
  - IDLE: start=1 → UNPACK.
  - UNPACK: special operand → PACK; otherwise → MULT.
  - MULT: 24 cycles, counter 0..23 → NORM.
  - NORM → ROUND → PACK → DONE → IDLE.
- Latency (start edge = edge 0): done is high after edge 28 for normal operands and after edge 2 for special operands.
- Start while busy or in DONE is ignored. Start in the same cycle as DONE is ignored. Start is accepted only in IDLE.
- UNPACK:
  - sign = sa^sb.
  - Hidden bit is set when exp≠0.
  - Denormal inputs (exp=0) are flushed to zero.
  - Exponent sum = ea+eb−BIAS, held as 10-bit signed.
- Special cases, handled in priority order:
  - Either operand NaN, or inf×0 → 0x7FC00000.
  - inf×x → sign|0x7F800000 with ovf=1.
  - zero×x → signed zero (sign|0x00000000).
- MULT: shift-add into a 48-bit accumulator, one multiplier bit per cycle, LSB first.
- NORM:
  - If product bit47=1: frac = p[46:24], r = p[23], s = |p[22:0], exp+1.
  - Else: frac = p[45:23], r = p[22], s = |p[21:0].
- ROUND:
  - Increment frac when r&&s.
  - Increment carry-out sets frac=0 and exp+1.
- PACK:
  - exp≥255 → sign|0x7F800000, ovf=1.
  - exp≤0 → signed zero, ovf=0.
  - Otherwise {sign, exp[7:0], frac}.
- done rises in the same cycle that result updates. busy falls in that cycle.

Optional Feature:
- Macro: FPMUL_RNE_EN.
- Defined: ROUND uses round-to-nearest-even; increment when r&&(s||frac[0]).
- Undefined: increment only when r&&s. Exact ties truncate.
- Latency is identical in both builds.

Decomposition:
- Package fpmul_pkg holds:
  - state enum (IDLE, UNPACK, MULT, NORM, ROUND, PACK, DONE);
  - EXP_W, FRAC_W, BIAS;
  - QNAN=0x7FC00000 and INF_MAG=0x7F800000;
  - the special-case classification type.
- Sub-module fp_round_inc: combinational 23-bit frac increment with carry-out, selected by the round condition.

Test Plan:
- 0x3FC00000 × 0x40000000 (1.5×2.0) → result 0x40400000, done exactly 28 cycles after the start edge, busy high for cycles 1–27.
- 0x80000000 × 0x3F800000 → 0x80000000 with done at cycle 2. 0x7F800000 × 0x00000000 → 0x7FC00000 with done at cycle 2.
- 0x7F000000 × 0x7F000000 → 0x7F800000, ovf=1. 0x00800000 × 0x00800000 → 0x00000000, ovf=0.
- Tie 0x3F800001 × 0x3FC00000 → 0x3FC00001 without FPMUL_RNE_EN; 0x3FC00002 with it.
- start pulsed at cycles 5 and 27 during an operation is ignored (result unchanged from the first operation). rst_n low during MULT → busy=0, done=0, result=0 asynchronously. After reset, a new start produces the correct product at +28.
